// File: rtl/bcd_scan_counter_if.sv
// rtl/bcd_scan_counter_if.sv - control and display signal bundle for bcd_scan_counter
interface bcd_scan_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      direction;
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_value;
  logic [4*NUM_DIGITS-1:0]   count;
  logic                      carry;
  logic [NUM_DIGITS-1:0]     select;
  logic [6:0]                digital;

  modport master (
    output direction, enable, load, load_value,
    input  count, carry, select, digital
  );

  modport slave (
    input  direction, enable, load, load_value,
    output count, carry, select, digital
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - multi-digit BCD up/down counter with multiplexed 7-segment scan
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LEADING_BLANK_EN.
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int TICK_DIV   = 200
) (
  input  logic            clk,
  input  logic            rst,
  bcd_scan_counter_if.slave bus
);
  localparam int W   = 4 * NUM_DIGITS;
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int STW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [STW-1:0] STEP_LAST = STW'(TICK_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [SCW-1:0]        scan_cnt;
  logic [STW-1:0]        step_cnt;
  logic [W-1:0]          count_q;
  logic                  carry_q;
  logic [IW-1:0]         sel_idx;
  logic [NUM_DIGITS-1:0] select_q;
  logic [6:0]            digital_q;

  logic                  scan_tick;
  logic                  step_now;
  logic [W-1:0]          count_up;
  logic [W-1:0]          count_dn;
  logic [W-1:0]          load_clean;
  logic                  up_wrap;
  logic                  dn_wrap;
  logic [IW-1:0]         next_idx;
  logic [3:0]            next_digit;
  logic                  blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign step_now  = scan_tick && (step_cnt == STEP_LAST);

  // Decimal ripple: carry/borrow keeps propagating while digits wrap.
  always_comb begin
    logic up_c;
    logic dn_b;
    count_up = count_q;
    count_dn = count_q;
    up_c     = 1'b1;
    dn_b     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (up_c) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          count_up[4*i +: 4] = 4'd0;
        end else begin
          count_up[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          up_c = 1'b0;
        end
      end
      if (dn_b) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dn[4*i +: 4] = 4'd9;
        end else begin
          count_dn[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dn_b = 1'b0;
        end
      end
    end
    up_wrap = up_c;
    dn_wrap = dn_b;
  end

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_clean[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_value[4*i +: 4];
    end
  end

  assign next_idx   = (sel_idx == IDX_LAST) ? '0 : sel_idx + IW'(1);
  assign next_digit = count_q[{next_idx, 2'b00} +: 4];

`ifdef BCD_SCAN_LEADING_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc && (count_q[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end
  end

  assign blank = (next_idx != '0) && zero_from[next_idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      step_cnt  <= '0;
      count_q   <= '0;
      carry_q   <= 1'b0;
      sel_idx   <= '0;
      select_q  <= NUM_DIGITS'(1);
      digital_q <= 7'h3F;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SCW'(1);
      if (scan_tick) begin
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STW'(1);
      end

      carry_q <= 1'b0;
      if (bus.load) begin
        count_q <= load_clean;
      end else if (step_now && bus.enable) begin
        if (bus.direction) begin
          count_q <= count_up;
          carry_q <= up_wrap;
        end else begin
          count_q <= count_dn;
          carry_q <= dn_wrap;
        end
      end

      // Display samples the pre-edge count for the slot being entered.
      if (scan_tick) begin
        sel_idx   <= next_idx;
        select_q  <= NUM_DIGITS'(1) << next_idx;
        digital_q <= blank ? 7'h00 : seg7(next_digit);
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.carry   = carry_q;
  assign bus.select  = select_q;
  assign bus.digital = digital_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - randomized self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;
  localparam int ND   = 2;
  localparam int SD   = 4;
  localparam int TD   = 2;
  localparam int MAXV = 99;

  logic clk = 1'b0;
  logic rst;

  bcd_scan_counter_if #(.NUM_DIGITS(ND)) bus ();

  bcd_scan_counter #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .TICK_DIV  (TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: cycles since reset, decimal value, display slot.
  int         m_cyc;
  int         m_val;
  bit         m_carry;
  int         m_sel;
  logic [6:0] m_dig;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction

  function automatic logic [6:0] ref_display(input int val, input int slot);
`ifdef BCD_SCAN_LEADING_BLANK_EN
    if (slot > 0 && val < 10 ** slot) return 7'h00;
`endif
    return ref_seg((val / (10 ** slot)) % 10);
  endfunction

  function automatic int ref_load(input logic [4*ND-1:0] lv);
    int v = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      int d = int'(lv[4*i +: 4]);
      v = v * 10 + ((d > 9) ? 0 : d);
    end
    return v;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic bit step_next();
    return ((m_cyc % SD) == SD - 1) && (((m_cyc / SD) % TD) == TD - 1);
  endfunction

  task automatic cycle(input bit r, input bit d, input bit e, input bit l, input logic [4*ND-1:0] lv);
    bit st;
    bit sp;
    int old;
    rst            = r;
    bus.direction  = d;
    bus.enable     = e;
    bus.load       = l;
    bus.load_value = lv;
    if (r) begin
      m_cyc = 0; m_val = 0; m_carry = 0; m_sel = 0; m_dig = 7'h3F;
    end else begin
      st  = (m_cyc % SD) == SD - 1;
      sp  = step_next();
      m_cyc++;
      old = m_val;
      m_carry = 0;
      if (l) begin
        m_val = ref_load(lv);
      end else if (sp && e) begin
        if (d) begin
          m_carry = (m_val == MAXV);
          m_val   = (m_val + 1) % (MAXV + 1);
        end else begin
          m_carry = (m_val == 0);
          m_val   = (m_val == 0) ? MAXV : m_val - 1;
        end
      end
      if (st) begin
        m_sel = (m_sel + 1) % ND;
        m_dig = ref_display(old, m_sel);
      end
    end
    @(posedge clk);
    #1;
    check("count",   32'(bus.count),   32'(to_bcd(m_val)));
    check("carry",   32'(bus.carry),   32'(m_carry));
    check("select",  32'(bus.select),  32'(1 << m_sel));
    check("digital", 32'(bus.digital), 32'(m_dig));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.direction = 1'b1; bus.enable = 1'b0; bus.load = 1'b0; bus.load_value = '0;

    cycle(1, 1, 0, 0, 8'h00);
    cycle(1, 1, 0, 0, 8'h00);
    check("rst_count",   32'(bus.count),   32'h00);
    check("rst_select",  32'(bus.select),  32'h01);
    check("rst_digital", 32'(bus.digital), 32'h3F);
    check("rst_carry",   32'(bus.carry),   32'h0);

    // Up through the 99 -> 00 wrap.
    cycle(0, 1, 1, 1, 8'h98);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 1, 0, 8'h00);
      n += int'(bus.carry);
    end
    check("up_wrap_count",  32'(bus.count), 32'h00);
    check("up_wrap_pulses", 32'(n), 32'd1);

    // Down through the 00 -> 99 wrap.
    cycle(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 8'h00);
    check("down_wrap_count", 32'(bus.count), 32'h99);

    // Load collides with a step; invalid digit is stored as 0.
    for (int i = 0; i < 16 && !step_next(); i++) cycle(0, 1, 1, 0, 8'h00);
    check("aligned_load", 32'(step_next()), 32'd1);
    cycle(0, 1, 1, 1, 8'h5C);
    check("load_prio_count", 32'(bus.count), 32'h50);
    check("load_prio_carry", 32'(bus.carry), 32'h0);

    // Frozen value while the display scans.
    cycle(0, 1, 0, 1, 8'h07);
    for (int i = 0; i < 24; i++) cycle(0, 1, 0, 0, 8'h00);
    check("frozen_count", 32'(bus.count), 32'h07);

    // Reset lands on what would have been a step edge.
    cycle(0, 1, 1, 1, 8'h42);
    for (int i = 0; i < 16 && !step_next(); i++) cycle(0, 1, 1, 0, 8'h00);
    cycle(1, 1, 1, 0, 8'h00);
    check("rst_step_count", 32'(bus.count), 32'h00);
    check("rst_step_carry", 32'(bus.carry), 32'h0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 8'h00);

    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 199) == 0, 1'($urandom), $urandom_range(0, 9) != 0,
            $urandom_range(0, 29) == 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
